// File: rtl/des_key_if.sv
// Handshake bundle between a key-schedule requester and the DES key scheduler.
// The master side requests schedules and consumes subkeys; the slave side produces them.
interface des_key_if;
  logic        start;
  logic [64:1] key;
  logic        decrypt;
  logic        busy;
  logic [48:1] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [4:0]  round;
  logic        done;

  modport master (
    output start, key, decrypt, subkey_ready,
    input  busy, subkey, subkey_valid, round, done
  );

  modport slave (
    input  start, key, decrypt, subkey_ready,
    output busy, subkey, subkey_valid, round, done
  );
endinterface

// File: rtl/des_key_scheduler.sv
// DES key schedule: PC-1 on start, then one C/D rotation per round and a registered PC-2 subkey
// presented over valid/ready. Decrypt mode walks the schedule backwards with right rotations.
module des_key_scheduler (
  input  logic      clk,
  input  logic      rst,
  des_key_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_e;

  state_e      state_q, state_d;
  logic [28:1] c_q, c_d, d_q, d_d;
  logic [56:1] cd0_q, cd0_d;
  logic        decrypt_q, decrypt_d;
  logic [48:1] subkey_q, subkey_d;
  logic [4:0]  round_q, round_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        busy;
  logic        accept;
  logic        start_ok;
  logic [4:0]  rot_round;
  logic [28:1] c_rot, d_rot;
  logic [56:1] cd_pc1;
  logic        unused_parity;

  // Vector index 64 is DES bit 1; the result is {C0, D0} with index 56 = C bit 1.
  function automatic logic [56:1] pc1(input logic [64:1] k);
    return {k[8],  k[16], k[24], k[32], k[40], k[48], k[56], k[64],
            k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
            k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
            k[5],  k[13], k[21], k[29],
            k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
            k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
            k[4],  k[12], k[20], k[28], k[36], k[44], k[52], k[60],
            k[37], k[45], k[53], k[61]};
  endfunction

  function automatic logic [48:1] pc2(input logic [28:1] c, input logic [28:1] d);
    logic [56:1] cd;
    cd = {c, d};
    return {cd[43], cd[40], cd[46], cd[33], cd[56], cd[52], cd[54], cd[29],
            cd[42], cd[51], cd[36], cd[47], cd[34], cd[38], cd[45], cd[53],
            cd[31], cd[49], cd[41], cd[50], cd[30], cd[37], cd[44], cd[55],
            cd[16], cd[5],  cd[26], cd[20], cd[10], cd[2],  cd[27], cd[17],
            cd[6],  cd[12], cd[24], cd[9],  cd[13], cd[8],  cd[18], cd[1],
            cd[23], cd[4],  cd[11], cd[15], cd[7],  cd[21], cd[28], cd[25]};
  endfunction

  // Round 17 is the restore step taken when K16 is accepted, so C/D end back at C0/D0.
  function automatic logic [1:0] shift_amt(input logic [4:0] r, input logic dec);
    logic single;
    if (dec) begin
      single    = (r == 5'd2) || (r == 5'd9) || (r == 5'd16) || (r == 5'd17);
      shift_amt = (r == 5'd1) ? 2'd0 : (single ? 2'd1 : 2'd2);
    end else begin
      single    = (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
      shift_amt = (r == 5'd17) ? 2'd0 : (single ? 2'd1 : 2'd2);
    end
  endfunction

  function automatic logic [28:1] rotate(input logic [28:1] x, input logic [1:0] amt,
                                         input logic left);
    logic [28:1] r;
    r = x;
    for (int i = 0; i < 2; i++) begin
      if (i < int'(amt)) r = left ? {r[27:1], r[28]} : {r[1], r[28:2]};
    end
    return r;
  endfunction

  // Parity bits never enter the schedule.
  assign unused_parity = ^{bus.key[57], bus.key[49], bus.key[41], bus.key[33],
                           bus.key[25], bus.key[17], bus.key[9],  bus.key[1]};

  assign accept    = valid_q & bus.subkey_ready;
  assign start_ok  = bus.start & ~done_q;
  assign cd_pc1    = pc1(bus.key);
  assign rot_round = (state_q == S_LOAD) ? 5'd1 : round_q + 5'd1;
  assign c_rot     = rotate(c_q, shift_amt(rot_round, decrypt_q), ~decrypt_q);
  assign d_rot     = rotate(d_q, shift_amt(rot_round, decrypt_q), ~decrypt_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_LOAD;
      S_LOAD:  state_d = S_OUT;
      S_OUT:   if (accept && round_q == 5'd16) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every always_comb target gets a hold/default value first, so no path infers a latch.
  always_comb begin
    c_d       = c_q;
    d_d       = d_q;
    cd0_d     = cd0_q;
    decrypt_d = decrypt_q;
    subkey_d  = subkey_q;
    round_d   = round_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          {c_d, d_d} = cd_pc1;
          cd0_d      = cd_pc1;
          decrypt_d  = bus.decrypt;
        end
      end
      S_LOAD: begin
        c_d      = c_rot;
        d_d      = d_rot;
        subkey_d = pc2(c_rot, d_rot);
        round_d  = 5'd1;
        valid_d  = 1'b1;
      end
      S_OUT: begin
        if (accept) begin
          c_d = c_rot;
          d_d = d_rot;
          if (round_q == 5'd16) begin
            subkey_d = '0;
            round_d  = 5'd0;
            valid_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            subkey_d = pc2(c_rot, d_rot);
            round_d  = round_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the C/D datapath is reset along
  // with the control flops so a mid-schedule reset leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q       <= '0;
      d_q       <= '0;
      cd0_q     <= '0;
      decrypt_q <= 1'b0;
      subkey_q  <= '0;
      round_q   <= 5'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      c_q       <= c_d;
      d_q       <= d_d;
      cd0_q     <= cd0_d;
      decrypt_q <= decrypt_d;
      subkey_q  <= subkey_d;
      round_q   <= round_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // The rotations total 28 in both modes, so C/D must have come back to their PC-1 values.
  always_ff @(posedge clk) begin
    if (!rst && done_q) assert ({c_q, d_q} == cd0_q);
  end

  assign bus.busy         = busy;
  assign bus.subkey       = subkey_q;
  assign bus.subkey_valid = valid_q;
  assign bus.round        = round_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler using the classic 133457799BBCDFF1 key schedule;
// covers encrypt/decrypt order, latency, backpressure, input interference, reset and parity.
module tb_des_key_scheduler;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  des_key_if bus ();

  des_key_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [64:1] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [64:1] PAR_MSK = 64'h0101010101010101;

  // K1..K16 for KEY_A.
  logic [48:1] exp_keys [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic begin_schedule(input logic [64:1] k, input logic dec);
    bus.key          = k;
    bus.decrypt      = dec;
    bus.start        = 1'b1;
    bus.subkey_ready = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in the cycle after start was accepted; returns in the done cycle.
  // mode 0: ready held high, 1: random ready with a 5-cycle stall at round 9,
  // 2: key/decrypt/start disturbed while round 4 is presented.
  task automatic consume(input string tag, input logic dec, input int mode);
    int          idx, cyc, first_cyc, stall_left;
    logic        held, early_done, prev_stall;
    logic [48:1] prev_sk;
    logic [4:0]  prev_rd;
    logic [64:1] k0;
    idx = 0; cyc = 1; first_cyc = 0; stall_left = 0;
    held = 1'b0; early_done = 1'b0; prev_stall = 1'b0;
    prev_sk = '0; prev_rd = '0; k0 = bus.key;
    check($sformatf("%s busy", tag), bus.busy, 1);
    check($sformatf("%s load", tag), bus.subkey_valid, 0);
    while (idx < 16 && cyc < 300) begin
      if (bus.done) early_done = 1'b1;
      case (mode)
        1: begin
          if (bus.round == 5'd9 && !held) begin
            stall_left = 5;
            held       = 1'b1;
          end
          if (stall_left > 0) begin
            bus.subkey_ready = 1'b0;
            stall_left--;
          end else begin
            bus.subkey_ready = 1'($urandom_range(0, 1));
          end
        end
        2: begin
          bus.subkey_ready = 1'b1;
          bus.start        = (bus.round == 5'd4);
          if (bus.round == 5'd4) begin
            bus.key     = ~k0;
            bus.decrypt = ~dec;
          end
        end
        default: bus.subkey_ready = 1'b1;
      endcase
      if (prev_stall) begin
        check($sformatf("%s stall key", tag), bus.subkey, prev_sk);
        check($sformatf("%s stall round", tag), bus.round, prev_rd);
        check($sformatf("%s stall valid", tag), bus.subkey_valid, 1);
      end
      if (bus.subkey_valid && first_cyc == 0) first_cyc = cyc;
      if (bus.subkey_valid && bus.subkey_ready) begin
        check($sformatf("%s key%0d", tag, idx + 1), bus.subkey,
              dec ? exp_keys[15 - idx] : exp_keys[idx]);
        check($sformatf("%s round%0d", tag, idx + 1), bus.round, idx + 1);
        idx++;
      end
      prev_stall = bus.subkey_valid && !bus.subkey_ready;
      prev_sk    = bus.subkey;
      prev_rd    = bus.round;
      tick();
      cyc++;
    end
    bus.start        = 1'b0;
    bus.decrypt      = dec;
    bus.subkey_ready = 1'b1;
    check($sformatf("%s keys delivered", tag), idx, 16);
    check($sformatf("%s early done", tag), early_done, 0);
    check($sformatf("%s done", tag), bus.done, 1);
    check($sformatf("%s busy at done", tag), bus.busy, 0);
    check($sformatf("%s valid at done", tag), bus.subkey_valid, 0);
    check($sformatf("%s round at done", tag), bus.round, 0);
    if (mode == 0) begin
      check($sformatf("%s first valid cycle", tag), first_cyc, 2);
      check($sformatf("%s done cycle", tag), cyc, 18);
    end
  endtask

  initial begin
    int n;
    compared = 0;
    mismatched = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    bus.decrypt = 1'b0;
    bus.subkey_ready = 1'b0;
    tick();
    tick();
    check("reset busy", bus.busy, 0);
    check("reset valid", bus.subkey_valid, 0);
    check("reset round", bus.round, 0);
    check("reset done", bus.done, 0);
    check("reset subkey", bus.subkey, 0);
    rst = 1'b0;
    tick();

    begin_schedule(KEY_A, 1'b0);
    consume("enc", 1'b0, 0);
    tick();
    check("done one cycle", bus.done, 0);

    begin_schedule(KEY_A, 1'b1);
    consume("dec", 1'b1, 0);
    tick();

    begin_schedule(KEY_A, 1'b0);
    consume("bp_enc", 1'b0, 1);
    tick();

    begin_schedule(KEY_A, 1'b1);
    consume("bp_dec", 1'b1, 1);
    tick();

    begin_schedule(KEY_A, 1'b0);
    consume("intf", 1'b0, 2);

    // start raised in the done cycle must wait one more cycle to be taken
    bus.key     = KEY_A;
    bus.decrypt = 1'b0;
    bus.start   = 1'b1;
    tick();
    check("start in done ignored", bus.busy, 0);
    tick();
    bus.start = 1'b0;
    consume("restart", 1'b0, 0);
    tick();

    begin_schedule(KEY_A, 1'b0);
    n = 0;
    while (bus.round != 5'd7 && n < 50) begin
      tick();
      n++;
    end
    check("reached round 7", bus.round, 7);
    rst = 1'b1;
    tick();
    check("mid rst busy", bus.busy, 0);
    check("mid rst valid", bus.subkey_valid, 0);
    check("mid rst round", bus.round, 0);
    check("mid rst done", bus.done, 0);
    check("mid rst subkey", bus.subkey, 0);
    rst = 1'b0;
    tick();
    check("no done after rst", bus.done, 0);
    check("idle after rst", bus.busy, 0);

    begin_schedule(KEY_A, 1'b0);
    consume("post_rst", 1'b0, 0);
    tick();

    begin_schedule(KEY_A ^ PAR_MSK, 1'b0);
    consume("parity_enc", 1'b0, 0);
    tick();

    begin_schedule(KEY_A ^ PAR_MSK, 1'b1);
    consume("parity_dec", 1'b1, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/des_key_scheduler.md
Name: des_key_scheduler

Overview:
- Sequences the DES key schedule around the 28-bit C/D rotate datapath.
- Latches a 64-bit key and applies PC-1 to form C0/D0.
- Per round, rotates C and D by 1 or 2 positions: left for encrypt, right for decrypt.
- Emits the 16 PC-2 48-bit round subkeys in order over a valid/ready handshake to the round-function pipeline.

Parameters:
- None. Widths are fixed by DES: key 64, half 28, subkey 48.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new schedule; sampled only in IDLE.
- key  input  [64:1]  DES key; DES bit n = key[65-n]; parity bits (DES 8,16,..,64) ignored.
- decrypt  input  1  sampled with start; 1 = emit K16..K1, 0 = emit K1..K16.
- busy  output  1  high from the cycle after start is accepted until done.
- subkey  output  [48:1]  round subkey; DES bit n = subkey[49-n]; registered.
- subkey_valid  output  1  subkey holds a valid round key.
- subkey_ready  input  1  consumer accepts subkey when valid & ready.
- round  output  [4:0]  round index 1..16 of the presented subkey; 0 when idle.
- done  output  1  one-cycle pulse after round 16 is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0 and state goes to IDLE; C, D and the latched decrypt flag are cleared.
  - Reset has priority over all other inputs, including mid-schedule; no done pulse is issued.
- Bit convention: vector index 28 = DES bit 1. Left rotate by 1 is {x[27:1], x[28]}; right rotate by 1 is {x[1], x[28:2]}.
- Shift table SH[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- States:
  - IDLE:
    - If start=1: C <= PC-1 left half, D <= PC-1 right half; latch decrypt; go to LOAD.
    - Else remain. busy=0.
  - LOAD (1 cycle):
    - Apply the round-1 rotation, register subkey <= PC-2(rotated C,D), round <= 1, subkey_valid <= 1; go to OUT.
  - OUT:
    - If subkey_valid & subkey_ready and round < 16: apply the rotation for round+1, update subkey, increment round. subkey_valid stays 1, giving one key per cycle when ready is held high.
    - If accepted at round 16: subkey_valid <= 0, round <= 0, done <= 1 for one cycle, go to IDLE (busy drops in the same cycle).
    - If subkey_ready=0: subkey, round, C and D hold unchanged (no bubbles, no drops).
- Rotation amount for round r:
  - Encrypt: rotate left by SH[r].
  - Decrypt: r=1 rotates by 0 (C16=C0); r>=2 rotates right by SH[18-r].
- Latency:
  - start accepted at cycle t; busy=1 from t+1; first subkey valid at t+2.
  - With ready tied high: round 16 is presented at t+17, done pulses at t+18.
- Inputs are not re-read mid-schedule:
  - start and decrypt are ignored while busy.
  - Changes to key after the start cycle have no effect.
- start asserted in the same cycle done pulses is ignored; a new start is accepted the following cycle (IDLE).
- After the final rotation, C and D must equal their post-PC-1 values in both modes (checked by assertion).
- Arithmetic: pure bit permutation; no carries. Rotation by 2 is two concatenated single rotates, performed in one cycle.

Test Plan:
- Reset, then encrypt with key=64'h133457799BBCDFF1, ready=1:
  - subkey at round 1 = 48'h1B02EFFC7072; at round 16 = 48'hCB3D8B0E17F5.
  - done pulses exactly at t+18; round runs 1..16 contiguously.
- Same key with decrypt=1:
  - round 1 subkey = 48'hCB3D8B0E17F5; round 16 = 48'h1B02EFFC7072.
  - All 16 keys are the encrypt sequence reversed.
- Backpressure: ready toggled randomly and held low 5 cycles at round 9:
  - subkey and round are stable while stalled; all 16 keys are delivered once, in order; done follows the last accepted key.
- Key/start interference: change key and pulse start at round 4:
  - Output sequence is unaffected; a start asserted in the done cycle is ignored, while start one cycle later begins a new schedule (busy=1 next cycle).
- rst asserted at round 7 with ready=1:
  - Next cycle all outputs = 0 and state is IDLE; no done pulse.
  - A subsequent start produces a correct full schedule from round 1.
- Parity-bit independence: flip all eight parity bits of the key:
  - All 16 subkeys are identical to the unflipped run.
